// File: rtl/time_of_day_counter.sv
// Time-of-day counter: accumulates tenth-second ticks into a 24-hour BCD
// clock (hh:mm:ss.t), accepts validated hh:mm loads, and emits second,
// minute, alarm-match and load-error strobes. All outputs are registered.
//
// Handshake: there is no valid/ready flow control here. tenth_sec_tc and
// load are single-cycle requests that are consumed on the edge they are
// sampled on. Each output strobe is high for exactly one cycle.
module time_of_day_counter #(
  parameter int TICKS_PER_SEC = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_ena,
  input  logic        tenth_sec_tc,
  input  logic        load,
  input  logic [15:0] load_time_bcd,
  input  logic        alarm_ena,
  input  logic [15:0] alarm_time_bcd,
  output logic [7:0]  hours_bcd,
  output logic [7:0]  minutes_bcd,
  output logic [7:0]  seconds_bcd,
  output logic [3:0]  tenths,
  output logic        sec_pulse,
  output logic        min_pulse,
  output logic        alarm_match,
  output logic        load_err
);

  localparam logic [3:0] TENTHS_MAX = 4'(TICKS_PER_SEC - 1);

  logic [7:0] hr_q, min_q, sec_q;
  logic [3:0] tenths_q;
  logic       sec_pulse_q, min_pulse_q, alarm_q, load_err_q;

  logic [7:0] hr_d, min_d, sec_d;
  logic [3:0] tenths_d;
  logic       sec_pulse_d, min_pulse_d, alarm_d, load_err_d;

  logic       tick, ld_valid, load_ok, count;
  logic       tenth_wrap, sec_wrap, min_wrap, hr_wrap;

  // Two-digit BCD increment; the caller handles the modulo wrap.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Decode load validity and the carry chain of the current time.
  always_comb begin
    tick       = clk_ena & tenth_sec_tc;
    ld_valid   = (load_time_bcd[15:12] <= 4'd2) &&
                 (load_time_bcd[11:8]  <= 4'd9) &&
                 (load_time_bcd[7:4]   <= 4'd5) &&
                 (load_time_bcd[3:0]   <= 4'd9) &&
                 !((load_time_bcd[15:12] == 4'd2) && (load_time_bcd[11:8] > 4'd3));
    load_ok    = load & ld_valid;
    // A valid load overrides a simultaneous tick; a rejected load does not.
    count      = tick & ~load_ok;
    tenth_wrap = (tenths_q == TENTHS_MAX);
    sec_wrap   = tenth_wrap && (sec_q == 8'h59);
    min_wrap   = sec_wrap && (min_q == 8'h59);
    hr_wrap    = min_wrap && (hr_q == 8'h23);
  end

  // Next-state time and strobes: load first, otherwise cascade a tick.
  always_comb begin
    hr_d        = hr_q;
    min_d       = min_q;
    sec_d       = sec_q;
    tenths_d    = tenths_q;
    sec_pulse_d = 1'b0;
    min_pulse_d = 1'b0;
    alarm_d     = 1'b0;
    load_err_d  = load & ~ld_valid;
    if (load_ok) begin
      hr_d     = load_time_bcd[15:8];
      min_d    = load_time_bcd[7:0];
      sec_d    = 8'h00;
      tenths_d = 4'd0;
    end else if (count) begin
      tenths_d = tenth_wrap ? 4'd0 : tenths_q + 4'd1;
      if (tenth_wrap) begin
        sec_d       = sec_wrap ? 8'h00 : bcd_inc(sec_q);
        sec_pulse_d = 1'b1;
      end
      if (sec_wrap) begin
        min_d       = min_wrap ? 8'h00 : bcd_inc(min_q);
        min_pulse_d = 1'b1;
      end
      if (min_wrap) begin
        hr_d = hr_wrap ? 8'h00 : bcd_inc(hr_q);
      end
      // Only a counted minute rollover can match, so loads and setpoint
      // edits never produce a strobe.
      alarm_d = sec_wrap && alarm_ena && ({hr_d, min_d} == alarm_time_bcd);
    end
  end

  // Time and strobe registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hr_q        <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      tenths_q    <= 4'd0;
      sec_pulse_q <= 1'b0;
      min_pulse_q <= 1'b0;
      alarm_q     <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      hr_q        <= hr_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      tenths_q    <= tenths_d;
      sec_pulse_q <= sec_pulse_d;
      min_pulse_q <= min_pulse_d;
      alarm_q     <= alarm_d;
      load_err_q  <= load_err_d;
    end
  end

  assign hours_bcd   = hr_q;
  assign minutes_bcd = min_q;
  assign seconds_bcd = sec_q;
  assign tenths      = tenths_q;
  assign sec_pulse   = sec_pulse_q;
  assign min_pulse   = min_pulse_q;
  assign alarm_match = alarm_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter. The reference model keeps the time as a
// single integer count of tenths since midnight and derives the BCD fields,
// strobes and load checks from it with plain arithmetic.
module tb_time_of_day_counter;

  localparam int TPS = 10;
  localparam int DAY = 86400 * TPS;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_ena;
  logic        tenth_sec_tc;
  logic        load;
  logic [15:0] load_time_bcd;
  logic        alarm_ena;
  logic [15:0] alarm_time_bcd;
  logic [7:0]  hours_bcd, minutes_bcd, seconds_bcd;
  logic [3:0]  tenths;
  logic        sec_pulse, min_pulse, alarm_match, load_err;

  time_of_day_counter #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .rst(rst), .clk_ena(clk_ena), .tenth_sec_tc(tenth_sec_tc),
    .load(load), .load_time_bcd(load_time_bcd), .alarm_ena(alarm_ena),
    .alarm_time_bcd(alarm_time_bcd), .hours_bcd(hours_bcd),
    .minutes_bcd(minutes_bcd), .seconds_bcd(seconds_bcd), .tenths(tenths),
    .sec_pulse(sec_pulse), .min_pulse(min_pulse), .alarm_match(alarm_match),
    .load_err(load_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] obs_vec;
  logic [31:0] exp_vec;
  int          n_vec = 0;
  int          n_err = 0;

  assign obs_vec = {hours_bcd, minutes_bcd, seconds_bcd, tenths,
                    sec_pulse, min_pulse, alarm_match, load_err};

  // ---------------- reference model ----------------
  int   tod;
  logic m_sp, m_mp, m_am, m_le;

  function automatic logic [7:0] to_bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] to_bcd16(input int h, input int m);
    return {to_bcd8(h), to_bcd8(m)};
  endfunction

  function automatic int bcd16_to_minute(input logic [15:0] b);
    return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 +
           int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [31:0] model_vec();
    int h, m, s, t;
    h = tod / (3600 * TPS);
    m = (tod / (60 * TPS)) % 60;
    s = (tod / TPS) % 60;
    t = tod % TPS;
    return {to_bcd8(h), to_bcd8(m), to_bcd8(s), 4'(t), m_sp, m_mp, m_am, m_le};
  endfunction

  task automatic model_reset();
    tod = 0; m_sp = 0; m_mp = 0; m_am = 0; m_le = 0;
  endtask

  task automatic model_step(input logic tc, input logic ena, input logic ld,
                            input logic [15:0] lt);
    int d3, d2, d1, d0;
    bit valid;
    d3 = int'(lt[15:12]); d2 = int'(lt[11:8]); d1 = int'(lt[7:4]); d0 = int'(lt[3:0]);
    valid = (d3 <= 9) && (d2 <= 9) && (d1 <= 9) && (d0 <= 9) &&
            (d3 * 10 + d2 <= 23) && (d1 <= 5);
    m_sp = 0; m_mp = 0; m_am = 0; m_le = 0;
    if (ld && valid) begin
      tod = ((d3 * 10 + d2) * 60 + d1 * 10 + d0) * 60 * TPS;
    end else begin
      if (ld) m_le = 1;
      if (tc && ena) begin
        tod  = (tod + 1) % DAY;
        m_sp = (tod % TPS) == 0;
        m_mp = (tod % (60 * TPS)) == 0;
        m_am = m_mp && alarm_ena &&
               ((tod / (60 * TPS)) == bcd16_to_minute(alarm_time_bcd));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic tc, input logic ena, input logic ld,
                       input logic [15:0] lt);
    @(negedge clk);
    tenth_sec_tc  = tc;
    clk_ena       = ena;
    load          = ld;
    load_time_bcd = lt;
    model_step(tc, ena, ld, lt);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    tenth_sec_tc = 1'b0;
    load         = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; clk_ena = 1'b0; tenth_sec_tc = 1'b0; load = 1'b0;
    load_time_bcd = 16'h0; alarm_ena = 1'b0; alarm_time_bcd = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    exp_vec = model_vec();
    n_vec++;
    if (obs_vec !== exp_vec) begin
      n_err++;
      $display("FAIL reset_hold: got %h expected %h", obs_vec, exp_vec);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    exp_vec = exp_q.pop_front();
    n_vec++;
    if (obs_vec !== exp_vec) begin
      n_err++;
      $display("FAIL reset_release: got %h expected %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_seconds();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      exp_vec = exp_q.pop_front();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL seconds_tick%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    n_vec++;
    if (seconds_bcd !== 8'h01 || tenths !== 4'd0 || sec_pulse !== 1'b1 || min_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL seconds_first: got s=%h t=%0d sp=%b mp=%b expected s=01 t=0 sp=1 mp=0",
               seconds_bcd, tenths, sec_pulse, min_pulse);
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    exp_vec = exp_q.pop_front();
    n_vec++;
    if (obs_vec !== exp_vec || sec_pulse !== 1'b0) begin
      n_err++;
      $display("FAIL seconds_pulse_drop: got %h expected %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_full_wrap();
    drive(1'b0, 1'b1, 1'b1, 16'h2359);
    exp_vec = exp_q.pop_front();
    n_vec++;
    if (obs_vec !== exp_vec) begin
      n_err++;
      $display("FAIL wrap_load: got %h expected %h", obs_vec, exp_vec);
    end
    for (int i = 1; i <= 600; i++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      exp_vec = exp_q.pop_front();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL wrap_tick%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    n_vec++;
    if (obs_vec !== 32'h0000_000C) begin
      n_err++;
      $display("FAIL wrap_midnight: got %h expected 0000000c", obs_vec);
    end
  endtask

  task automatic test_invalid_load();
    logic [15:0] bad [4] = '{16'h2400, 16'h1260, 16'h0A00, 16'h09F0};
    drive(1'b0, 1'b1, 1'b1, 16'h0506);
    void'(exp_q.pop_front());
    for (int i = 0; i < 73; i++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      exp_vec = exp_q.pop_front();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL invalid_setup%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, bad[i]);
      exp_vec = exp_q.pop_front();
      n_vec++;
      if (obs_vec !== exp_vec || obs_vec !== 32'h0506_0731) begin
        n_err++;
        $display("FAIL invalid_load_%h: got %h expected %h", bad[i], obs_vec, exp_vec);
      end
    end
    // A rejected load alongside a tick still counts the tick.
    drive(1'b1, 1'b1, 1'b1, 16'h2400);
    exp_vec = exp_q.pop_front();
    n_vec++;
    if (obs_vec !== exp_vec) begin
      n_err++;
      $display("FAIL invalid_with_tick: got %h expected %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_alarm();
    alarm_time_bcd = 16'h0730;
    for (int pass = 0; pass < 2; pass++) begin
      alarm_ena = (pass == 0);
      drive(1'b0, 1'b1, 1'b1, 16'h0729);
      void'(exp_q.pop_front());
      for (int i = 1; i <= 600; i++) begin
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        exp_vec = exp_q.pop_front();
        n_vec++;
        if (obs_vec !== exp_vec) begin
          n_err++;
          $display("FAIL alarm_p%0d_tick%0d: got %h expected %h", pass, i, obs_vec, exp_vec);
        end
      end
      n_vec++;
      if (alarm_match !== (pass == 0) || {hours_bcd, minutes_bcd} !== 16'h0730) begin
        n_err++;
        $display("FAIL alarm_p%0d_final: got am=%b hm=%h expected am=%b hm=0730",
                 pass, alarm_match, {hours_bcd, minutes_bcd}, pass == 0);
      end
    end
    alarm_ena = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 16'h0730);
    exp_vec = exp_q.pop_front();
    n_vec++;
    if (obs_vec !== exp_vec || alarm_match !== 1'b0) begin
      n_err++;
      $display("FAIL alarm_by_load: got %h expected %h", obs_vec, exp_vec);
    end
    alarm_ena = 1'b0;
  endtask

  task automatic test_load_tick_and_disable();
    drive(1'b1, 1'b1, 1'b0, 16'h0);
    void'(exp_q.pop_front());
    drive(1'b1, 1'b1, 1'b1, 16'h1000);
    exp_vec = exp_q.pop_front();
    n_vec++;
    if (obs_vec !== exp_vec || obs_vec !== 32'h1000_0000) begin
      n_err++;
      $display("FAIL load_beats_tick: got %h expected %h", obs_vec, exp_vec);
    end
    drive(1'b1, 1'b1, 1'b0, 16'h0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0);
      exp_vec = exp_q.pop_front();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL disabled_tick%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    // Loads are still honoured while counting is disabled.
    drive(1'b0, 1'b0, 1'b1, 16'h1545);
    exp_vec = exp_q.pop_front();
    n_vec++;
    if (obs_vec !== exp_vec) begin
      n_err++;
      $display("FAIL disabled_load: got %h expected %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    logic        tc, ena, ld;
    logic [15:0] lt;
    int          h, m;
    for (int i = 0; i < 4000; i++) begin
      tc  = ($urandom_range(0, 3) != 0);
      ena = ($urandom_range(0, 7) != 0);
      ld  = ($urandom_range(0, 699) == 0);
      h   = $urandom_range(0, 23);
      m   = $urandom_range(0, 59);
      lt  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : to_bcd16(h, m);
      if (ld && $urandom_range(0, 1) == 1) begin
        alarm_ena      = 1'b1;
        alarm_time_bcd = to_bcd16((h + (m + 1) / 60) % 24, (m + 1) % 60);
      end else if ($urandom_range(0, 999) == 0) begin
        alarm_ena = ~alarm_ena;
      end
      drive(tc, ena, ld, lt);
      exp_vec = exp_q.pop_front();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random%0d: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b1, 16'h1234);
    void'(exp_q.pop_front());
    for (int i = 0; i < 567; i++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      void'(exp_q.pop_front());
    end
    n_vec++;
    if (obs_vec !== model_vec() || obs_vec !== 32'h1234_5670) begin
      n_err++;
      $display("FAIL async_setup: got %h expected 12345670", obs_vec);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs_vec !== model_vec()) begin
      n_err++;
      $display("FAIL async_clear: got %h expected %h", obs_vec, model_vec());
    end
    #1;
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 16'h0);
    exp_vec = exp_q.pop_front();
    n_vec++;
    if (obs_vec !== exp_vec || tenths !== 4'd1) begin
      n_err++;
      $display("FAIL async_resume: got %h expected %h", obs_vec, exp_vec);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_seconds();
    test_full_wrap();
    test_invalid_load();
    test_alarm();
    test_load_tick_and_disable();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
